// File: rtl/aq_dcache_tag_ctrl.sv
// Tag-array port sequencer: arbitrates LSU lookups, refill writes and the
// CP0 invalidate-all sweep onto the single dcache tag SRAM port.
module aq_dcache_tag_ctrl #(
  parameter int unsigned TAG_LEN    = 28,
  parameter int unsigned SET_NUM    = 64,
  parameter int unsigned STARVE_LIM = 4
) (
  input  logic                forever_cpuclk,
  input  logic                cpurst_b,
  input  logic                cp0_lsu_dcache_inv_req,
  output logic                lsu_dcache_inv_done,
  output logic                ctrl_busy,
  input  logic                rd_req,
  input  logic [11:0]         rd_idx,
  output logic                rd_gnt,
  output logic                rd_data_vld,
  input  logic                wr_req,
  input  logic [11:0]         wr_idx,
  input  logic [3:0]          wr_way,
  input  logic [TAG_LEN-1:0]  wr_tag,
  input  logic                wr_vld,
  output logic                wr_gnt,
  output logic                tag_cen,
  output logic                tag_clk_en,
  output logic                tag_gwen,
  output logic [11:0]         tag_idx,
  output logic [3:0]          tag_way,
  output logic [119:0]        tag_wen,
  output logic [119:0]        tag_din
);

  localparam int unsigned WAYS   = 4;
  localparam int unsigned SLOT_W = 30;
  localparam int unsigned SET_W  = 6;
  localparam int unsigned CNT_W  = (SET_NUM > 1) ? $clog2(SET_NUM) : 1;
  localparam int unsigned STV_W  = $clog2(STARVE_LIM + 1);

  localparam logic [SLOT_W-1:0] VLD_MASK = SLOT_W'(1) << (SLOT_W - 1);
  localparam logic [SLOT_W-1:0] TAG_MASK = SLOT_W'((64'(1) << TAG_LEN) - 64'(1));
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(SET_NUM - 1);
  localparam logic [STV_W-1:0]  STV_LIM  = STV_W'(STARVE_LIM);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    INV  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   set_cnt_q, set_cnt_d;
  logic [STV_W-1:0]   starve_q, starve_d;
  logic               rd_vld_q;
  logic               sweep_wr;
  logic [SLOT_W-1:0]  wr_slot;

  // State, sweep counter, starvation counter and read-data-valid registers
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      state_q   <= IDLE;
      set_cnt_q <= '0;
      starve_q  <= '0;
      rd_vld_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      set_cnt_q <= set_cnt_d;
      starve_q  <= starve_d;
      rd_vld_q  <= rd_gnt;
    end
  end

  // Next state, arbitration and array drive for the current cycle
  always_comb begin
    state_d             = state_q;
    set_cnt_d           = set_cnt_q;
    rd_gnt              = 1'b0;
    wr_gnt              = 1'b0;
    sweep_wr            = 1'b0;
    lsu_dcache_inv_done = 1'b0;
    tag_gwen            = 1'b1;
    tag_idx             = '0;
    tag_way             = '0;
    tag_wen             = '1;
    tag_din             = '0;
    wr_slot             = {wr_vld, 29'(wr_tag)};

    unique case (state_q)
      IDLE: begin
        if (cp0_lsu_dcache_inv_req) begin
          state_d   = INV;
          set_cnt_d = '0;
        end else if (rd_req && (!wr_req || (starve_q == STV_LIM))) begin
          rd_gnt = 1'b1;
        end else if (wr_req) begin
          wr_gnt = 1'b1;
        end
      end
      INV: begin
        sweep_wr  = 1'b1;
        set_cnt_d = set_cnt_q + CNT_W'(1);
        if (set_cnt_q == CNT_LAST) state_d = DONE;
      end
      DONE: begin
        lsu_dcache_inv_done = 1'b1;
        state_d             = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (rd_gnt) begin
      tag_idx = rd_idx;
      tag_way = 4'b1111;
    end else if (wr_gnt) begin
      tag_idx  = wr_idx;
      tag_way  = wr_way;
      tag_gwen = 1'b0;
      for (int w = 0; w < WAYS; w++) begin
        tag_din[w*SLOT_W +: SLOT_W] = wr_slot;
        if (wr_way[w]) tag_wen[w*SLOT_W +: SLOT_W] = ~(VLD_MASK | TAG_MASK);
      end
    end else if (sweep_wr) begin
      tag_idx  = {SET_W'(set_cnt_q), 6'b0};
      tag_way  = 4'b1111;
      tag_gwen = 1'b0;
      for (int w = 0; w < WAYS; w++) begin
        tag_wen[w*SLOT_W +: SLOT_W] = ~VLD_MASK;
      end
    end

    if (rd_req && !rd_gnt) begin
      starve_d = (starve_q == STV_LIM) ? starve_q : starve_q + STV_W'(1);
    end else begin
      starve_d = '0;
    end
  end

  // Array enables follow any access; status outputs come straight from registers
  assign tag_clk_en  = rd_gnt | wr_gnt | sweep_wr;
  assign tag_cen     = ~tag_clk_en;
  assign rd_data_vld = rd_vld_q;
  assign ctrl_busy   = (state_q == INV) || (state_q == DONE);

endmodule

// File: tb/tb_aq_dcache_tag_ctrl.sv
// Directed self-checking bench for aq_dcache_tag_ctrl.
module tb_aq_dcache_tag_ctrl;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         inv_req;
  logic         inv_done;
  logic         busy;
  logic         rd_req;
  logic [11:0]  rd_idx;
  logic         rd_gnt;
  logic         rd_data_vld;
  logic         wr_req;
  logic [11:0]  wr_idx;
  logic [3:0]   wr_way;
  logic [27:0]  wr_tag;
  logic         wr_vld;
  logic         wr_gnt;
  logic         tag_cen;
  logic         tag_clk_en;
  logic         tag_gwen;
  logic [11:0]  tag_idx;
  logic [3:0]   tag_way;
  logic [119:0] tag_wen;
  logic [119:0] tag_din;

  int n_pass = 0;
  int n_tot  = 0;

  always #5 clk = ~clk;

  aq_dcache_tag_ctrl #(.TAG_LEN(28), .SET_NUM(64), .STARVE_LIM(4)) dut (
    .forever_cpuclk         (clk),
    .cpurst_b               (rst_n),
    .cp0_lsu_dcache_inv_req (inv_req),
    .lsu_dcache_inv_done    (inv_done),
    .ctrl_busy              (busy),
    .rd_req                 (rd_req),
    .rd_idx                 (rd_idx),
    .rd_gnt                 (rd_gnt),
    .rd_data_vld            (rd_data_vld),
    .wr_req                 (wr_req),
    .wr_idx                 (wr_idx),
    .wr_way                 (wr_way),
    .wr_tag                 (wr_tag),
    .wr_vld                 (wr_vld),
    .wr_gnt                 (wr_gnt),
    .tag_cen                (tag_cen),
    .tag_clk_en             (tag_clk_en),
    .tag_gwen               (tag_gwen),
    .tag_idx                (tag_idx),
    .tag_way                (tag_way),
    .tag_wen                (tag_wen),
    .tag_din                (tag_din)
  );

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
  endtask

  task automatic chkw(input string tag, input logic [119:0] obs, input logic [119:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Advance to just after the next rising edge, where inputs are changed
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Checks that the array port is in its no-access state
  task automatic chk_idle(input string tag);
    chk1({tag, ".cen"}, tag_cen, 1'b1);
    chk1({tag, ".clk_en"}, tag_clk_en, 1'b0);
    chk1({tag, ".gwen"}, tag_gwen, 1'b1);
    chkw({tag, ".wen"}, tag_wen, {120{1'b1}});
    chkw({tag, ".idx"}, 120'(tag_idx), 120'(0));
    chkw({tag, ".way"}, 120'(tag_way), 120'(0));
    chkw({tag, ".din"}, tag_din, 120'(0));
  endtask

  logic [119:0] exp_wen;
  logic [119:0] sweep_wen;
  logic [5:0]   arb_wr;
  logic [5:0]   set_v;

  initial begin
    rst_n   = 1'b0;
    inv_req = 1'b0;
    rd_req  = 1'b0;
    rd_idx  = '0;
    wr_req  = 1'b0;
    wr_idx  = '0;
    wr_way  = '0;
    wr_tag  = '0;
    wr_vld  = 1'b0;

    sweep_wen      = {120{1'b1}};
    sweep_wen[29]  = 1'b0;
    sweep_wen[59]  = 1'b0;
    sweep_wen[89]  = 1'b0;
    sweep_wen[119] = 1'b0;

    // Reset state
    #2;
    chk_idle("reset");
    chk1("reset.rd_gnt", rd_gnt, 1'b0);
    chk1("reset.wr_gnt", wr_gnt, 1'b0);
    chk1("reset.rd_data_vld", rd_data_vld, 1'b0);
    chk1("reset.inv_done", inv_done, 1'b0);
    chk1("reset.busy", busy, 1'b0);
    tick();
    tick();
    rst_n = 1'b1;

    // Idle with no requests
    for (int i = 0; i < 10; i++) begin
      tick();
      chk1("idle.cen", tag_cen, 1'b1);
      chk1("idle.clk_en", tag_clk_en, 1'b0);
      chkw("idle.wen", tag_wen, {120{1'b1}});
      chk1("idle.rd_data_vld", rd_data_vld, 1'b0);
    end

    // Single-cycle read
    rd_req = 1'b1;
    rd_idx = 12'h3C0;
    #1;
    chk1("rd.gnt", rd_gnt, 1'b1);
    chk1("rd.wr_gnt", wr_gnt, 1'b0);
    chk1("rd.cen", tag_cen, 1'b0);
    chk1("rd.clk_en", tag_clk_en, 1'b1);
    chk1("rd.gwen", tag_gwen, 1'b1);
    chkw("rd.idx", 120'(tag_idx), 120'(12'h3C0));
    chkw("rd.way", 120'(tag_way), 120'(4'hF));
    chkw("rd.wen", tag_wen, {120{1'b1}});
    chk1("rd.vld_same_cycle", rd_data_vld, 1'b0);
    tick();
    rd_req = 1'b0;
    #1;
    chk1("rd.vld_next", rd_data_vld, 1'b1);
    chk_idle("rd.after");
    tick();
    chk1("rd.vld_once", rd_data_vld, 1'b0);

    // Refill write into way 2
    wr_req = 1'b1;
    wr_idx = 12'h5A4;
    wr_way = 4'b0100;
    wr_tag = 28'h1234567;
    wr_vld = 1'b1;
    exp_wen = {120{1'b1}};
    exp_wen[89] = 1'b0;
    exp_wen[87:60] = 28'h0;
    #1;
    chk1("wr.gnt", wr_gnt, 1'b1);
    chk1("wr.rd_gnt", rd_gnt, 1'b0);
    chk1("wr.cen", tag_cen, 1'b0);
    chk1("wr.gwen", tag_gwen, 1'b0);
    chkw("wr.idx", 120'(tag_idx), 120'(12'h5A4));
    chkw("wr.way", 120'(tag_way), 120'(4'b0100));
    chkw("wr.wen", tag_wen, exp_wen);
    chkw("wr.din", tag_din, {4{30'h21234567}});

    // Write with no way selected: granted, nothing written
    tick();
    wr_way = 4'b0000;
    wr_vld = 1'b0;
    wr_tag = 28'hFFFFFFF;
    #1;
    chk1("wr0.gnt", wr_gnt, 1'b1);
    chk1("wr0.cen", tag_cen, 1'b0);
    chk1("wr0.gwen", tag_gwen, 1'b0);
    chkw("wr0.wen", tag_wen, {120{1'b1}});
    chkw("wr0.din", tag_din, {4{30'h0FFFFFFF}});
    tick();
    wr_req = 1'b0;
    chk1("wr.no_rd_vld", rd_data_vld, 1'b0);

    // Read and write contending: read forced through after four losses
    arb_wr = 6'b101111;
    rd_req = 1'b1;
    rd_idx = 12'h040;
    wr_req = 1'b1;
    wr_way = 4'b0001;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk1($sformatf("arb%0d.wr_gnt", i), wr_gnt, arb_wr[i]);
      chk1($sformatf("arb%0d.rd_gnt", i), rd_gnt, ~arb_wr[i]);
      tick();
    end
    rd_req = 1'b0;
    wr_req = 1'b0;
    wr_way = '0;
    #1;
    chk_idle("arb.after");
    tick();

    // Invalidate-all sweep
    inv_req = 1'b1;
    #1;
    chk_idle("inv.start");
    chk1("inv.start.busy", busy, 1'b0);
    tick();
    for (int i = 0; i < 64; i++) begin
      set_v = 6'(i);
      if (i == 30) rd_req = 1'b1;
      #1;
      chkw($sformatf("sw%0d.idx", i), 120'(tag_idx), 120'({set_v, 6'b0}));
      chkw($sformatf("sw%0d.way", i), 120'(tag_way), 120'(4'hF));
      chk1($sformatf("sw%0d.gwen", i), tag_gwen, 1'b0);
      chk1($sformatf("sw%0d.cen", i), tag_cen, 1'b0);
      chkw($sformatf("sw%0d.wen", i), tag_wen, sweep_wen);
      chkw($sformatf("sw%0d.din", i), tag_din, 120'(0));
      chk1($sformatf("sw%0d.busy", i), busy, 1'b1);
      chk1($sformatf("sw%0d.done", i), inv_done, 1'b0);
      chk1($sformatf("sw%0d.rd_gnt", i), rd_gnt, 1'b0);
      tick();
    end
    #1;
    chk1("inv.done", inv_done, 1'b1);
    chk1("inv.done.busy", busy, 1'b1);
    chk1("inv.done.rd_gnt", rd_gnt, 1'b0);
    chk_idle("inv.done");
    inv_req = 1'b0;
    tick();
    chk1("inv.post.done", inv_done, 1'b0);
    chk1("inv.post.busy", busy, 1'b0);
    chk1("inv.post.rd_gnt", rd_gnt, 1'b1);
    tick();
    rd_req = 1'b0;
    chk1("inv.post.rd_vld", rd_data_vld, 1'b1);
    tick();

    // Reset in the middle of a sweep, then restart from set 0
    inv_req = 1'b1;
    tick();
    for (int i = 0; i < 20; i++) tick();
    #1;
    chkw("mid.idx", 120'(tag_idx), 120'({6'd20, 6'b0}));
    rst_n = 1'b0;
    #1;
    chk_idle("mid.rst");
    chk1("mid.rst.busy", busy, 1'b0);
    chk1("mid.rst.done", inv_done, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk1("mid.rst.hold_done", inv_done, 1'b0);
      chk1("mid.rst.hold_cen", tag_cen, 1'b1);
    end
    rst_n = 1'b1;
    #1;
    chk_idle("restart.idle");
    chk1("restart.idle.busy", busy, 1'b0);
    tick();
    chkw("restart.set0", 120'(tag_idx), 120'(0));
    chk1("restart.set0.gwen", tag_gwen, 1'b0);
    chk1("restart.set0.busy", busy, 1'b1);
    tick();
    chkw("restart.set1", 120'(tag_idx), 120'({6'd1, 6'b0}));
    inv_req = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/aq_dcache_tag_ctrl.md
Name: aq_dcache_tag_ctrl

Overview:
- Sequencer and arbiter in front of the LSU dcache tag array (4 ways, 2 banks, 64 sets, 30-bit way slots).
- Shares the single SRAM port between three requesters: the load/store tag lookup (read), the refill tag write, and a CP0-initiated invalidate-all sweep.
- Drives the tag array's cen/clk_en/gwen/idx/way/wen/din and reports read-data timing and sweep completion.

Parameters:
- TAG_LEN, 28, tag field width per way; must satisfy TAG_LEN <= 28.
- SET_NUM, 64, number of sets; the sweep counter runs 0..SET_NUM-1.
- STARVE_LIM, 4, consecutive cycles a read may lose to writes before it is forced to win.

Ports:
- forever_cpuclk  in  1  clock.
- cpurst_b  in  1  asynchronous active-low reset.
- cp0_lsu_dcache_inv_req  in  1  level; held high until the done pulse.
- lsu_dcache_inv_done  out  1  one-cycle pulse when the sweep completes.
- ctrl_busy  out  1  high in states INV and DONE.
- rd_req  in  1  read request.
- rd_idx  in  12  read address; bits [11:6] are the set.
- rd_gnt  out  1  read accepted this cycle.
- rd_data_vld  out  1  tag_dout is valid (cycle after rd_gnt).
- wr_req  in  1  refill write request.
- wr_idx  in  12  write address.
- wr_way  in  4  one-hot target way(s).
- wr_tag  in  TAG_LEN  tag value.
- wr_vld  in  1  valid bit value.
- wr_gnt  out  1  write accepted this cycle.
- tag_cen  out  1  active-low chip enable.
- tag_clk_en  out  1  array clock enable.
- tag_gwen  out  1  active-low global write enable.
- tag_idx  out  12  array address.
- tag_way  out  4  way/bank select.
- tag_wen  out  120  per-bit active-low write enable.
- tag_din  out  120  write data.

Behaviour:
- Way slot layout: way w occupies bits [30w+29 : 30w]. Bit 30w+29 is valid; [30w+TAG_LEN-1 : 30w] is tag. All other slot bits are never written (wen=1, din=0).
- The interface is fully combinational to the array in the request cycle; the SRAM samples on the next clock edge.
- Access = rd_gnt | wr_gnt | sweep write.
  - tag_clk_en = access; tag_cen = ~access.
- No access: tag_cen=1, tag_gwen=1, tag_wen all 1, tag_idx=0, tag_way=0, tag_din=0.
- Reset values: all outputs at the no-access values; rd_gnt, wr_gnt, rd_data_vld, lsu_dcache_inv_done, ctrl_busy all 0. State=IDLE, set counter=0, starve counter=0.
- FSM states: IDLE, INV, DONE.
  - IDLE, inv_req=1: no grants this cycle; go to INV with set counter=0.
  - INV: each cycle write set=counter into all ways.
    - tag_idx[11:6]=counter, other tag_idx bits 0; tag_way=4'b1111; tag_gwen=0.
    - tag_wen=0 only on the four valid bits; tag_din=0.
    - Counter increments each cycle. After the write with counter=SET_NUM-1, go to DONE.
    - rd_req and wr_req are never granted in INV.
  - DONE: one cycle; lsu_dcache_inv_done=1, no access; go to IDLE.
  - If inv_req is still high on returning to IDLE, a new sweep starts.
  - A sweep takes SET_NUM+2 cycles from the first IDLE cycle that sees inv_req to the end of DONE.
- IDLE arbitration when inv_req=0:
  - Writes win over reads, except reads win when starve counter == STARVE_LIM.
  - Starve counter: +1 (saturating at STARVE_LIM) each cycle rd_req=1 and rd_gnt=0; cleared on rd_gnt or rd_req=0.
- Read grant drives: tag_idx=rd_idx, tag_way=4'b1111, tag_gwen=1, tag_wen all 1.
- Write grant drives:
  - tag_idx=wr_idx, tag_way=wr_way, tag_gwen=0.
  - Every slot's din = {wr_vld, 0, tag zero-extended}.
  - wen=0 on the valid and tag bits of selected ways only.
  - wr_way=0 with wr_req=1: still granted; no bits written.
- rd_data_vld: registered rd_gnt, exactly one cycle later. A read granted in the cycle before entering INV still produces rd_data_vld.
- Reset mid-sweep: state returns to IDLE, counter to 0, no done pulse. Requester must re-issue.

Test Plan:
- Reset, then idle with no requests -> tag_cen=1, tag_clk_en=0, tag_wen=all 1, rd_data_vld=0 for 10 cycles.
- rd_req=1, rd_idx=12'h3C0, single cycle -> rd_gnt=1, tag_idx=12'h3C0, tag_way=4'hF, tag_gwen=1; rd_data_vld=1 the next cycle only.
- wr_req=1, wr_way=4'b0100, wr_tag=28'h1234567, wr_vld=1 -> wr_gnt=1, tag_gwen=0. Bits [89:60] of tag_wen: bit 89 and [87:60] = 0, rest = 1; tag_din[89]=1, tag_din[87:60]=28'h1234567.
- rd_req and wr_req both held high for 6 cycles -> wr_gnt in cycles 0–3, rd_gnt in cycle 4, wr_gnt in cycle 5.
- cp0_lsu_dcache_inv_req pulsed high (held) from idle -> 64 write cycles with tag_idx[11:6]=0..63, tag_way=4'hF, tag_wen zero only at bits 29/59/89/119. lsu_dcache_inv_done pulses at cycle 65; rd_req raised mid-sweep is granted only after DONE.
- cpurst_b asserted at sweep cycle 20 -> outputs return to reset values immediately; no inv_done pulse; after release with inv_req held, sweep restarts at set 0.
